floo_axis_chan_scheduler: RTL and testbench
===========================================

Name: floo_axis_chan_scheduler

Overview:
Credit-based scheduler that time-multiplexes the NoC request and response flit channels onto a single AXIS link, one flit per beat, tagged with a channel ID in tuser. It sits between the FlooNoC router port and the serial-link AXIS interface. It replaces the packed req+rsp beat with per-channel arbitration. Per-channel credits mirror the free buffer space in the remote receiver.

Parameters:
ReqWidth, 64, payload width of a request flit (bits)
RspWidth, 64, payload width of a response flit (bits)
NumCredits, 8, remote receive-buffer depth per channel; initial credit count
MaxBurst, 4, maximum consecutive beats for one channel while the other channel is eligible
DataWidth, max(ReqWidth,RspWidth), localparam, AXIS tdata width
CntWidth, $clog2(NumCredits+1), localparam, credit counter width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-high
req_valid_i  in  1  request flit valid
req_ready_o  out  1  request flit accepted
req_data_i  in  ReqWidth  request flit payload
rsp_valid_i  in  1  response flit valid
rsp_ready_o  out  1  response flit accepted
rsp_data_i  in  RspWidth  response flit payload
credit_req_i  in  1  one-cycle pulse: remote freed one request slot
credit_rsp_i  in  1  one-cycle pulse: remote freed one response slot
axis_tvalid_o  out  1  AXIS beat valid
axis_tready_i  in  1  AXIS beat accepted
axis_tdata_o  out  DataWidth  flit payload, zero-extended
axis_tuser_o  out  1  channel ID: 0 = req, 1 = rsp
req_credits_o  out  CntWidth  current request credits
rsp_credits_o  out  CntWidth  current response credits

Behaviour:
- Reset values: axis_tvalid_o=0, axis_tdata_o=0, axis_tuser_o=0, credits=NumCredits on both channels, last_ch=req, burst_cnt=0. Ready outputs are combinational and therefore 0 while no input is valid.
- Output slot: single register. load_en = !axis_tvalid_o | axis_tready_i, so the slot reloads in the same cycle it drains. Full throughput is 1 beat/cycle.
- Latency: a flit accepted in cycle N appears on axis_tvalid_o in cycle N+1.
- AXIS stability: while tvalid=1 and tready=0, tdata and tuser hold. tvalid never drops without a handshake.
- Eligibility: elig_c = valid_c & (credits_c != 0).
- Grant, evaluated only when load_en:
  - If exactly one channel is eligible, grant it.
  - If both are eligible and burst_cnt < MaxBurst, grant last_ch; otherwise grant the other channel.
  - If none is eligible, no grant and tvalid goes to 0 on the next edge if drained.
- Ready: ready_c = load_en & grant_c. Ready may depend on valid. Upstream valid must not depend on ready.
- Burst update on each grant g:
  - If g==last_ch, burst_cnt = min(burst_cnt+1, MaxBurst).
  - Otherwise last_ch=g and burst_cnt=1.
  - No change on idle cycles.
- Credits per channel:
  - Decrement on grant; increment on the credit pulse.
  - Grant and pulse in the same cycle: count unchanged.
  - Decrement is impossible at 0, because eligibility is gated.
  - A pulse at NumCredits saturates (no wrap) and fires an assertion.
- A channel at 0 credits is skipped entirely. The other channel may then stream indefinitely, because the burst limit applies only when both channels are eligible.
- Reset mid-operation: any pending beat is discarded and credits restore to NumCredits. The remote side is reset in the same domain.
- Assertions:
  - AXIS stability.
  - No credit overflow.
  - req_ready_o & rsp_ready_o never both 1.

Decomposition:
- floo_axis_pkg: chan_e enum (ChanReq=0, ChanRsp=1) and the tuser width constant (1).
- Sub-module floo_credit_counter (params NumCredits; ports clk_i, rst_i, consume_i, return_i, credits_o, avail_o, overflow_o), instantiated once per channel.
- Arbitration and the output register live in the top module.

Test Plan:
1. Reset with NumCredits=8 and no traffic -> tvalid=0, both credit outputs =8, both ready =0.
2. Both channels valid continuously, tready=1, credit pulses echo each beat one cycle later -> tuser sequence 0,0,0,0,1,1,1,1,0… (MaxBurst=4), one beat per cycle.
3. req only valid, no credit returns -> exactly 8 beats with tuser=0, then req_ready_o=0 and tvalid=0. A single credit_req_i pulse releases exactly one more beat.
4. tready held 0 for 5 cycles with a beat pending (tdata=0xA5, tuser=1) -> tdata and tuser stable. Inputs are not accepted until tready=1, then the next flit appears the following cycle.
5. Simultaneous grant and credit_rsp_i pulse at rsp_credits=3 -> rsp_credits stays 3. A credit pulse at count 8 -> count stays 8 and the overflow assertion fires.
6. Assert rst_i while a beat is pending and credits=2 -> tvalid=0 immediately (asynchronous), both credit counts =8, last_ch=req.

Source files
------------

// File: rtl/floo_axis_pkg.sv
// Shared types for the FlooNoC AXIS channel scheduler: channel IDs and tuser width.
package floo_axis_pkg;

  typedef enum logic {
    ChanReq = 1'b0,
    ChanRsp = 1'b1
  } chan_e;

  localparam int unsigned TuserWidth = 1;

endpackage

// File: rtl/floo_credit_counter.sv
// Per-channel credit counter mirroring free slots in the remote receive buffer.
// Saturates at NumCredits; overflow_o flags a return pulse arriving when already full.
module floo_credit_counter #(
  parameter  int unsigned NumCredits = 8,
  localparam int unsigned CntWidth   = $clog2(NumCredits + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                consume_i,
  input  logic                return_i,
  output logic [CntWidth-1:0] credits_o,
  output logic                avail_o,
  output logic                overflow_o
);

  localparam logic [CntWidth-1:0] Full = CntWidth'(NumCredits);

  logic [CntWidth-1:0] cnt_reg;
  logic [CntWidth-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    unique case ({consume_i, return_i})
      2'b10:   cnt_next = cnt_reg - 1'b1;
      2'b01:   cnt_next = (cnt_reg == Full) ? cnt_reg : cnt_reg + 1'b1;
      default: cnt_next = cnt_reg;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_reg <= Full;
    else       cnt_reg <= cnt_next;
  end

  assign credits_o  = cnt_reg;
  assign avail_o    = (cnt_reg != '0);
  assign overflow_o = return_i & ~consume_i & (cnt_reg == Full);

endmodule

// File: rtl/floo_axis_chan_scheduler.sv
// Time-multiplexes NoC req/rsp flits onto one AXIS link, one flit per beat, with
// per-channel credits and a burst limit that only applies while both channels compete.
module floo_axis_chan_scheduler
  import floo_axis_pkg::*;
#(
  parameter  int unsigned ReqWidth   = 64,
  parameter  int unsigned RspWidth   = 64,
  parameter  int unsigned NumCredits = 8,
  parameter  int unsigned MaxBurst   = 4,
  localparam int unsigned DataWidth  = (ReqWidth > RspWidth) ? ReqWidth : RspWidth,
  localparam int unsigned CntWidth   = $clog2(NumCredits + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ReqWidth-1:0]   req_data_i,
  input  logic                  rsp_valid_i,
  output logic                  rsp_ready_o,
  input  logic [RspWidth-1:0]   rsp_data_i,
  input  logic                  credit_req_i,
  input  logic                  credit_rsp_i,
  output logic                  axis_tvalid_o,
  input  logic                  axis_tready_i,
  output logic [DataWidth-1:0]  axis_tdata_o,
  output logic [TuserWidth-1:0] axis_tuser_o,
  output logic [CntWidth-1:0]   req_credits_o,
  output logic [CntWidth-1:0]   rsp_credits_o
);

  localparam int unsigned BurstWidth = $clog2(MaxBurst + 1);
  localparam logic [BurstWidth-1:0] BurstMax = BurstWidth'(MaxBurst);

  logic                  tvalid_reg;
  logic [DataWidth-1:0]  tdata_reg;
  logic [TuserWidth-1:0] tuser_reg;
  chan_e                 last_ch_reg;
  logic [BurstWidth-1:0] burst_cnt_reg;

  logic                  load_en;
  logic                  grant_req, grant_rsp, grant_any;
  chan_e                 grant_ch, pick;
  logic [DataWidth-1:0]  tdata_next;

  logic [1:0]            consume, ret, avail, overflow;
  logic [CntWidth-1:0]   credits [2];

  assign consume = {grant_rsp, grant_req};
  assign ret     = {credit_rsp_i, credit_req_i};

  for (genvar gi = 0; gi < 2; gi++) begin : g_credit
    floo_credit_counter #(
      .NumCredits (NumCredits)
    ) u_credit (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .consume_i  (consume[gi]),
      .return_i   (ret[gi]),
      .credits_o  (credits[gi]),
      .avail_o    (avail[gi]),
      .overflow_o (overflow[gi])
    );
  end

  // The slot refills in the same cycle it drains, giving one beat per cycle.
  assign load_en = !tvalid_reg || axis_tready_i;

  always_comb begin
    grant_req = 1'b0;
    grant_rsp = 1'b0;
    pick      = last_ch_reg;
    if (load_en) begin
      if (req_valid_i && avail[0] && rsp_valid_i && avail[1]) begin
        pick      = (burst_cnt_reg < BurstMax) ? last_ch_reg : chan_e'(~last_ch_reg);
        grant_req = (pick == ChanReq);
        grant_rsp = (pick == ChanRsp);
      end else begin
        grant_req = req_valid_i && avail[0];
        grant_rsp = rsp_valid_i && avail[1];
      end
    end
  end

  assign grant_any = grant_req || grant_rsp;
  assign grant_ch  = grant_rsp ? ChanRsp : ChanReq;

  always_comb begin
    tdata_next = '0;
    if (grant_rsp) tdata_next[RspWidth-1:0] = rsp_data_i;
    else           tdata_next[ReqWidth-1:0] = req_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tvalid_reg <= 1'b0;
      tdata_reg  <= '0;
      tuser_reg  <= '0;
    end else if (load_en) begin
      tvalid_reg <= grant_any;
      if (grant_any) begin
        tdata_reg <= tdata_next;
        tuser_reg <= TuserWidth'(grant_ch);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_ch_reg   <= ChanReq;
      burst_cnt_reg <= '0;
    end else if (grant_any) begin
      if (grant_ch == last_ch_reg) begin
        if (burst_cnt_reg != BurstMax) burst_cnt_reg <= burst_cnt_reg + 1'b1;
      end else begin
        last_ch_reg   <= grant_ch;
        burst_cnt_reg <= BurstWidth'(1);
      end
    end
  end

  assign req_ready_o   = grant_req;
  assign rsp_ready_o   = grant_rsp;
  assign axis_tvalid_o = tvalid_reg;
  assign axis_tdata_o  = tdata_reg;
  assign axis_tuser_o  = tuser_reg;
  assign req_credits_o = credits[0];
  assign rsp_credits_o = credits[1];

  a_axis_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (axis_tvalid_o && !axis_tready_i) |=>
      (axis_tvalid_o && $stable(axis_tdata_o) && $stable(axis_tuser_o)));

  a_one_ready: assert property (@(posedge clk_i) disable iff (rst_i)
    !(req_ready_o && rsp_ready_o));

  // A credit return at full count is a remote protocol error; the counter saturates.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) overflow == 2'b00)
    else $warning("credit overflow: return pulse at full count, counter saturated");

endmodule

// File: tb/tb_floo_axis_chan_scheduler.sv
// Directed bench for floo_axis_chan_scheduler: a per-cycle behavioural model plus
// literal expectations for burst order, credit exhaustion, stalls and reset.
module tb_floo_axis_chan_scheduler;

  localparam int N    = 8;
  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, rsp_valid = 1'b0;
  logic        req_ready, rsp_ready;
  logic [63:0] req_data = '0, rsp_data = '0;
  logic        credit_req = 1'b0, credit_rsp = 1'b0;
  logic        axis_tvalid;
  logic        axis_tready = 1'b1;
  logic [63:0] axis_tdata;
  logic [0:0]  axis_tuser;
  logic [3:0]  req_credits, rsp_credits;

  int n_checks = 0;
  int n_pass   = 0;

  floo_axis_chan_scheduler #(
    .ReqWidth (64), .RspWidth (64), .NumCredits (N), .MaxBurst (MAXB)
  ) dut (
    .clk_i (clk), .rst_i (rst),
    .req_valid_i (req_valid), .req_ready_o (req_ready), .req_data_i (req_data),
    .rsp_valid_i (rsp_valid), .rsp_ready_o (rsp_ready), .rsp_data_i (rsp_data),
    .credit_req_i (credit_req), .credit_rsp_i (credit_rsp),
    .axis_tvalid_o (axis_tvalid), .axis_tready_i (axis_tready),
    .axis_tdata_o (axis_tdata), .axis_tuser_o (axis_tuser),
    .req_credits_o (req_credits), .rsp_credits_o (rsp_credits)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: credits per channel, the slot contents and the burst owner.
  int          m_cred [2];
  int          m_last, m_burst, m_user;
  bit          m_valid;
  logic [63:0] m_data;
  int          g_upd, g_cmp;

  function automatic int model_grant();
    bit can_load = !m_valid || axis_tready;
    bit e0 = req_valid && (m_cred[0] > 0);
    bit e1 = rsp_valid && (m_cred[1] > 0);
    if (!can_load) return -1;
    if (e0 && e1) return (m_burst < MAXB) ? m_last : 1 - m_last;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cred[0] = N; m_cred[1] = N;
      m_last = 0; m_burst = 0; m_valid = 0; m_data = '0; m_user = 0;
    end else begin
      g_upd = model_grant();
      m_cred[0] = m_cred[0] + int'(credit_req) - ((g_upd == 0) ? 1 : 0);
      m_cred[1] = m_cred[1] + int'(credit_rsp) - ((g_upd == 1) ? 1 : 0);
      if (m_cred[0] > N) m_cred[0] = N;
      if (m_cred[1] > N) m_cred[1] = N;
      if (!m_valid || axis_tready) begin
        m_valid = (g_upd >= 0);
        if (g_upd >= 0) begin
          m_user = g_upd;
          m_data = (g_upd == 0) ? req_data : rsp_data;
        end
      end
      if (g_upd >= 0) begin
        if (g_upd == m_last) m_burst = (m_burst < MAXB) ? m_burst + 1 : MAXB;
        else begin m_last = g_upd; m_burst = 1; end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      g_cmp = model_grant();
      check("model_tvalid", {63'd0, axis_tvalid}, {63'd0, m_valid});
      if (m_valid) begin
        check("model_tdata", axis_tdata, m_data);
        check("model_tuser", {63'd0, axis_tuser}, 64'(m_user));
      end
      check("model_req_credits", {60'd0, req_credits}, 64'(m_cred[0]));
      check("model_rsp_credits", {60'd0, rsp_credits}, 64'(m_cred[1]));
      check("model_req_ready", {63'd0, req_ready}, {63'd0, g_cmp == 0});
      check("model_rsp_ready", {63'd0, rsp_ready}, {63'd0, g_cmp == 1});
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    req_valid = 0; rsp_valid = 0; credit_req = 0; credit_rsp = 0; axis_tready = 1;
    rst = 1;
    step(); step();
    rst = 0;
  endtask

  initial begin
    logic [12:0] seq;
    int          nb, beats;

    // 1: reset state
    do_reset();
    @(negedge clk);
    check("reset_tvalid", {63'd0, axis_tvalid}, 64'd0);
    check("reset_req_credits", {60'd0, req_credits}, 64'd8);
    check("reset_rsp_credits", {60'd0, rsp_credits}, 64'd8);
    check("reset_readies", {62'd0, req_ready, rsp_ready}, 64'd0);

    // 2: both channels streaming with echoed credits
    step();
    req_valid = 1; rsp_valid = 1; req_data = 64'h1000; rsp_data = 64'h2000;
    seq = '0; nb = 0;
    for (int i = 0; i < 13; i++) begin
      step();
      req_data = 64'h1001 + 64'(i); rsp_data = 64'h2001 + 64'(i);
      credit_req = axis_tvalid && (axis_tuser == 1'b0);
      credit_rsp = axis_tvalid && (axis_tuser == 1'b1);
      if (axis_tvalid) begin seq[12 - nb] = axis_tuser[0]; nb++; end
    end
    req_valid = 0; rsp_valid = 0;
    step();
    credit_req = 0; credit_rsp = 0;
    check("burst_beats", 64'(nb), 64'd13);
    check("burst_order", {51'd0, seq}, {51'd0, 13'b0000111100001});
    step(); step();

    // 3: request credits run out, one returned credit releases one beat
    do_reset();
    req_valid = 1; req_data = 64'hCAFE;
    beats = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (axis_tvalid && axis_tuser == 1'b0) beats++;
    end
    check("req_exhaust_beats", 64'(beats), 64'd8);
    @(negedge clk);
    check("req_exhaust_ready", {63'd0, req_ready}, 64'd0);
    check("req_exhaust_tvalid", {63'd0, axis_tvalid}, 64'd0);
    check("req_exhaust_credits", {60'd0, req_credits}, 64'd0);
    step();
    credit_req = 1;
    step();
    credit_req = 0;
    beats = 0;
    for (int i = 0; i < 5; i++) begin
      if (axis_tvalid) beats++;
      step();
    end
    check("req_release_beats", 64'(beats), 64'd1);
    req_valid = 0;

    // 4: AXIS backpressure holds the pending beat
    do_reset();
    axis_tready = 0; rsp_valid = 1; rsp_data = 64'hA5;
    step();
    rsp_data = 64'h5A;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_tdata", axis_tdata, 64'hA5);
      check("stall_tuser", {63'd0, axis_tuser}, 64'd1);
      check("stall_rsp_ready", {63'd0, rsp_ready}, 64'd0);
      step();
    end
    axis_tready = 1;
    @(negedge clk);
    check("unstall_rsp_ready", {63'd0, rsp_ready}, 64'd1);
    step();
    rsp_valid = 0;
    @(negedge clk);
    check("unstall_next_tdata", axis_tdata, 64'h5A);
    check("unstall_next_tuser", {63'd0, axis_tuser}, 64'd1);
    step();

    // 5: grant and credit return together, then saturation at full count
    do_reset();
    rsp_valid = 1; rsp_data = 64'h77;
    for (int i = 0; i < 5; i++) step();
    check("rsp_credits_at_3", {60'd0, rsp_credits}, 64'd3);
    credit_rsp = 1;
    step();
    check("grant_plus_return", {60'd0, rsp_credits}, 64'd3);
    rsp_valid = 0;
    for (int i = 0; i < 5; i++) step();
    check("rsp_credits_refilled", {60'd0, rsp_credits}, 64'd8);
    step();
    credit_rsp = 0;
    check("rsp_credits_saturate", {60'd0, rsp_credits}, 64'd8);
    step();

    // 6: asynchronous reset with a pending beat and partly used credits
    do_reset();
    req_valid = 1; req_data = 64'h11;
    for (int i = 0; i < 6; i++) step();
    req_valid = 0; rsp_valid = 1; rsp_data = 64'h22;
    step();
    axis_tready = 0;
    check("pre_reset_req_credits", {60'd0, req_credits}, 64'd2);
    @(posedge clk); #2;
    rst = 1;
    #1;
    check("async_reset_tvalid", {63'd0, axis_tvalid}, 64'd0);
    check("async_reset_credits", {56'd0, req_credits, rsp_credits}, 64'h88);
    step();
    rst = 0;
    req_valid = 1; rsp_valid = 1; axis_tready = 1;
    step();
    check("post_reset_first_tuser", {63'd0, axis_tuser}, 64'd0);
    req_valid = 0; rsp_valid = 0;
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
